// File: rtl/order_display_pkg.sv
// order_display_pkg
//   Shared types and constants for the order queue display: the per-slot
//   state enum and record, the pixel colour-select codes carried down the
//   render pipeline, and the fixed panel colours.
package order_display_pkg;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_ACTIVE  = 2'd1,
    SLOT_EXPIRED = 2'd2
  } slot_state_e;

  typedef struct packed {
    slot_state_e state;
    logic [1:0]  dish;
    logic [4:0]  timer;
  } slot_t;

  // Colour source chosen at raster time, resolved once ROM data arrives.
  typedef enum logic [2:0] {
    PIX_NONE     = 3'd0,
    PIX_ROM      = 3'd1,
    PIX_BAR_OK   = 3'd2,
    PIX_BAR_WARN = 3'd3,
    PIX_EXPIRED  = 3'd4
  } pix_sel_e;

  localparam logic [11:0] COL_BAR_OK   = 12'h070;
  localparam logic [11:0] COL_BAR_WARN = 12'hF80;
  localparam logic [11:0] COL_EXPIRED  = 12'h700;
  localparam logic [11:0] COL_BLANK    = 12'h000;

endpackage

// File: rtl/order_slot_timer.sv
// order_slot_timer
//   One order slot: FREE/ACTIVE/EXPIRED state, dish type and countdown timer.
//   An expired slot lingers for two further time units, then frees itself.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   add_i         load this slot with a new order (only honoured when FREE)
//   type_i        dish type for the new order
//   done_i        serve this slot (ignored when FREE)
//   unit_tick_i   one-cycle time-unit strobe
//   slot_o        current slot record
//   expired_o     one-cycle pulse when the timer runs out
module order_slot_timer
  import order_display_pkg::*;
#(
  parameter int unsigned MAX_TIME = 31
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       add_i,
  input  logic [1:0] type_i,
  input  logic       done_i,
  input  logic       unit_tick_i,
  output slot_t      slot_o,
  output logic       expired_o
);

  slot_state_e state_q, state_d;
  logic [1:0]  dish_q, dish_d;
  logic [4:0]  timer_q, timer_d;
  logic        hold_q, hold_d;      // one unit already spent in EXPIRED
  logic        expired_q, expired_d;

  always_comb begin
    state_d   = state_q;
    dish_d    = dish_q;
    timer_d   = timer_q;
    hold_d    = hold_q;
    expired_d = 1'b0;
    case (state_q)
      SLOT_FREE: begin
        if (add_i) begin
          state_d = SLOT_ACTIVE;
          dish_d  = type_i;
          timer_d = 5'(MAX_TIME);
          hold_d  = 1'b0;
        end
      end
      SLOT_ACTIVE: begin
        if (done_i) begin
          state_d = SLOT_FREE;
          timer_d = '0;
        end else if (unit_tick_i && timer_q != '0) begin
          timer_d = timer_q - 5'd1;
          if (timer_q == 5'd1) begin
            state_d   = SLOT_EXPIRED;
            hold_d    = 1'b0;
            expired_d = 1'b1;
          end
        end
      end
      SLOT_EXPIRED: begin
        if (done_i) begin
          state_d = SLOT_FREE;
          timer_d = '0;
          hold_d  = 1'b0;
        end else if (unit_tick_i) begin
          if (hold_q) begin
            state_d = SLOT_FREE;
            hold_d  = 1'b0;
          end else begin
            hold_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = SLOT_FREE;
        timer_d = '0;
        hold_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= SLOT_FREE;
      dish_q    <= '0;
      timer_q   <= '0;
      hold_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dish_q    <= dish_d;
      timer_q   <= timer_d;
      hold_q    <= hold_d;
      expired_q <= expired_d;
    end
  end

  assign slot_o    = '{state: state_q, dish: dish_q, timer: timer_q};
  assign expired_o = expired_q;

endmodule

// File: rtl/order_queue_display.sv
// order_queue_display
//   Order queue with per-order countdown timers, rendered as a row of dish
//   icons with a timer bar under each. Build option: define WARN_FLASH_EN to
//   blink warning bars off while frame-counter bit 4 is set.
// Ports:
//   pixel_clk_in, rst_in           clock, asynchronous active-high reset
//   x_in, y_in                     panel origin
//   hcount_in, vcount_in           raster position
//   frame_tick_in                  one pulse per frame
//   order_add_in, order_type_in    add an order of a dish type
//   order_done_in, order_done_slot_in  serve the order in a slot
//   rom_addr_out, rom_data_in      sprite ROM {type,row,col} -> RGB444
//   pixel_out                      RGB444, ROM_LAT+2 cycles after raster input
//   full_out                       no free slot
//   expired_out                    one-cycle pulse on any expiry
module order_queue_display
  import order_display_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned SPRITE_W  = 32,
  parameter int unsigned SPRITE_H  = 32,
  parameter int unsigned SLOT_GAP  = 8,
  parameter int unsigned MAX_TIME  = 31,
  parameter int unsigned WARN_TIME = 8,
  parameter int unsigned TICK_DIV  = 60,
  parameter int unsigned ROM_LAT   = 2
) (
  input  logic                         pixel_clk_in,
  input  logic                         rst_in,
  input  logic [9:0]                   x_in,
  input  logic [8:0]                   y_in,
  input  logic [9:0]                   hcount_in,
  input  logic [8:0]                   vcount_in,
  input  logic                         frame_tick_in,
  input  logic                         order_add_in,
  input  logic [1:0]                   order_type_in,
  input  logic                         order_done_in,
  input  logic [$clog2(NUM_SLOTS)-1:0] order_done_slot_in,
  output logic [11:0]                  rom_addr_out,
  input  logic [11:0]                  rom_data_in,
  output logic [11:0]                  pixel_out,
  output logic                         full_out,
  output logic                         expired_out
);

  localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
  localparam int unsigned PW     = $clog2(TICK_DIV + 1);
  localparam int unsigned PITCH  = SPRITE_W + SLOT_GAP;

  // ---------------- slot bank ----------------
  slot_t                slots [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] add_vec, done_vec, free_vec, exp_vec;
  logic                 alloc_found;

  // Allocation looks only at registered state, so a slot freed this cycle
  // is not visible as FREE until the next one.
  always_comb begin
    add_vec     = '0;
    done_vec    = '0;
    free_vec    = '0;
    alloc_found = 1'b0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      free_vec[k] = (slots[k].state == SLOT_FREE);
      done_vec[k] = order_done_in && (order_done_slot_in == SLOT_W'(k));
      if (order_add_in && free_vec[k] && !alloc_found) begin
        add_vec[k]  = 1'b1;
        alloc_found = 1'b1;
      end
    end
  end

  // ---------------- time-unit prescaler ----------------
  logic [PW-1:0] presc_q, presc_d;
  logic          unit_tick;

  assign unit_tick = frame_tick_in && (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    presc_d = presc_q;
    if (frame_tick_in) presc_d = unit_tick ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) presc_q <= '0;
    else        presc_q <= presc_d;
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    order_slot_timer #(
      .MAX_TIME(MAX_TIME)
    ) u_slot (
      .clk_i      (pixel_clk_in),
      .rst_i      (rst_in),
      .add_i      (add_vec[g]),
      .type_i     (order_type_in),
      .done_i     (done_vec[g]),
      .unit_tick_i(unit_tick),
      .slot_o     (slots[g]),
      .expired_o  (exp_vec[g])
    );
  end

  assign full_out    = &(~free_vec);
  assign expired_out = |exp_vec;

  // ---------------- warning flash ----------------
  logic flash_blank;
`ifdef WARN_FLASH_EN
  logic [4:0] frame_cnt_q;
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in)             frame_cnt_q <= '0;
    else if (frame_tick_in) frame_cnt_q <= frame_cnt_q + 5'd1;
  end
  assign flash_blank = frame_cnt_q[4];
`else
  assign flash_blank = 1'b0;
`endif

  // ---------------- render: stage 0 region decode ----------------
  logic [11:0] hx, vy, top, left;
  logic        in_icon_rows, in_bar_rows;
  pix_sel_e    sel_d;
  logic [11:0] addr_d;

  always_comb begin
    sel_d        = PIX_NONE;
    addr_d       = '0;
    left         = '0;
    hx           = 12'(hcount_in);
    vy           = 12'(vcount_in);
    top          = 12'(y_in);
    in_icon_rows = (vy >= top) && (vy < top + 12'(SPRITE_H));
    in_bar_rows  = (vy >= top + 12'(SPRITE_H + 2)) && (vy <= top + 12'(SPRITE_H + 5));
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      left = 12'(x_in) + 12'(k * PITCH);
      if (in_icon_rows && hx >= left && hx < left + 12'(SPRITE_W)) begin
        addr_d = {slots[k].dish, 5'(vy - top), 5'(hx - left)};
        case (slots[k].state)
          SLOT_ACTIVE:  sel_d = PIX_ROM;
          SLOT_EXPIRED: sel_d = PIX_EXPIRED;
          default:      sel_d = PIX_NONE;
        endcase
      end else if (in_bar_rows && slots[k].state == SLOT_ACTIVE &&
                   hx >= left && hx < left + 12'(slots[k].timer)) begin
        if (32'(slots[k].timer) <= WARN_TIME)
          sel_d = flash_blank ? PIX_NONE : PIX_BAR_WARN;
        else
          sel_d = PIX_BAR_OK;
      end
    end
  end

  // ---------------- render: ROM-aligned pipeline ----------------
  // sel_q[0] launches with the ROM address; sel_q[ROM_LAT] lines up with
  // rom_data_in, and the output register adds the final cycle.
  logic [11:0] rom_addr_q;
  pix_sel_e    sel_q [ROM_LAT+1];
  logic [11:0] pixel_q, pixel_d;

  always_comb begin
    pixel_d = COL_BLANK;
    case (sel_q[ROM_LAT])
      PIX_ROM:      pixel_d = rom_data_in;
      PIX_BAR_OK:   pixel_d = COL_BAR_OK;
      PIX_BAR_WARN: pixel_d = COL_BAR_WARN;
      PIX_EXPIRED:  pixel_d = COL_EXPIRED;
      default:      pixel_d = COL_BLANK;
    endcase
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      rom_addr_q <= '0;
      pixel_q    <= '0;
      for (int unsigned i = 0; i <= ROM_LAT; i++) sel_q[i] <= PIX_NONE;
    end else begin
      rom_addr_q <= addr_d;
      pixel_q    <= pixel_d;
      sel_q[0]   <= sel_d;
      for (int unsigned i = 1; i <= ROM_LAT; i++) sel_q[i] <= sel_q[i-1];
    end
  end

  assign rom_addr_out = rom_addr_q;
  assign pixel_out    = pixel_q;

endmodule
